// File: rtl/dbl_framebuf_if.sv
// Display, update and swap-control signals of the double-buffered framebuffer.
// master = panel/update logic, slave = framebuffer.
interface dbl_framebuf_if #(
  parameter int ROW_BITS   = 3,
  parameter int COL_BITS   = 6,
  parameter int COLOR_BITS = 8
);
  localparam int AW = ROW_BITS + COL_BITS;
  localparam int W  = 3 * COLOR_BITS;

  logic [ROW_BITS-1:0]   disp_row;
  logic [COL_BITS-1:0]   disp_col;
  logic                  disp_frame_end;
  logic [COLOR_BITS-1:0] red;
  logic [COLOR_BITS-1:0] green;
  logic [COLOR_BITS-1:0] blue;
  logic [AW-1:0]         wr_addr;
  logic                  wr_en;
  logic [W-1:0]          wr_data;
  logic                  wr_ready;
  logic [W-1:0]          rd_q;
  logic                  swap_req;
  logic                  swap_busy;
  logic                  swap_done;
  logic                  front_sel;

  modport master (
    output disp_row, disp_col, disp_frame_end, wr_addr, wr_en, wr_data, swap_req,
    input  red, green, blue, wr_ready, rd_q, swap_busy, swap_done, front_sel
  );

  modport slave (
    input  disp_row, disp_col, disp_frame_end, wr_addr, wr_en, wr_data, swap_req,
    output red, green, blue, wr_ready, rd_q, swap_busy, swap_done, front_sel
  );
endinterface

// File: rtl/dbl_framebuf.sv
// Double-buffered RGB framebuffer: display reads the front bank, update side
// owns the back bank, swaps land on frame boundaries with optional clear.
module dbl_framebuf_bank #(
  parameter int AW = 9,
  parameter int W  = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Read-first: the same edge that writes still returns the old word.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else        q <= mem[raddr];
endmodule

module dbl_framebuf #(
  parameter int ROW_BITS      = 3,
  parameter int COL_BITS      = 6,
  parameter int COLOR_BITS    = 8,
  parameter int ROW_LOOKAHEAD = 1,
  parameter int HALF_SWAP     = 1,
  parameter int CLEAR_ON_SWAP = 0,
  parameter logic [3*COLOR_BITS-1:0] CLEAR_VAL = '0
) (
  input logic          clk,
  input logic          rst_n,
  dbl_framebuf_if.slave bus
);
  localparam int AW = ROW_BITS + COL_BITS;
  localparam int W  = 3 * COLOR_BITS;
  localparam logic [COL_BITS-1:0] COL_FLIP =
    (HALF_SWAP != 0) ? {1'b1, {(COL_BITS-1){1'b0}}} : '0;

  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wreq_t;

  state_t          state, state_nxt;
  logic            front_sel, front_nxt;
  logic            done_q, done_nxt;
  logic [AW-1:0]   clr_cnt, cnt_nxt;
  logic            rsel;
  logic            clearing;
  logic [ROW_BITS-1:0] row_la;
  logic [AW-1:0]   disp_addr;
  wreq_t           wreq;
  logic [1:0][W-1:0] bank_q;
  logic [W-1:0]    pix;

  assign row_la    = bus.disp_row + ROW_BITS'(ROW_LOOKAHEAD);
  assign disp_addr = {row_la, bus.disp_col ^ COL_FLIP};
  assign clearing  = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      done_q    <= 1'b0;
      clr_cnt   <= '0;
      rsel      <= 1'b0;
    end else begin
      state     <= state_nxt;
      front_sel <= front_nxt;
      done_q    <= done_nxt;
      clr_cnt   <= cnt_nxt;
      rsel      <= front_sel;
    end

  always_comb begin
    state_nxt = state;
    front_nxt = front_sel;
    done_nxt  = 1'b0;
    cnt_nxt   = clr_cnt;
    case (state)
      IDLE:
        if (bus.swap_req) state_nxt = PENDING;
      PENDING:
        if (bus.disp_frame_end) begin
          front_nxt = ~front_sel;
          if (CLEAR_ON_SWAP != 0) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      CLEAR: begin
        cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == '1) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Back-bank write port: the clear engine owns it while clearing.
  always_comb begin
    wreq.en   = bus.wr_en;
    wreq.addr = bus.wr_addr;
    wreq.data = bus.wr_data;
    if (clearing) begin
      wreq.en   = 1'b1;
      wreq.addr = clr_cnt;
      wreq.data = CLEAR_VAL;
    end
  end

  // Each bank serves the display when front, the update port when back.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_front;
    assign is_front = (front_sel == 1'(b));
    dbl_framebuf_bank #(.AW(AW), .W(W)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wreq.en && !is_front),
      .waddr (wreq.addr),
      .wdata (wreq.data),
      .raddr (is_front ? disp_addr : bus.wr_addr),
      .q     (bank_q[b])
    );
  end

  assign pix           = bank_q[rsel];
  assign bus.red       = pix[COLOR_BITS-1:0];
  assign bus.green     = pix[2*COLOR_BITS-1:COLOR_BITS];
  assign bus.blue      = pix[W-1:2*COLOR_BITS];
  assign bus.rd_q      = bank_q[~rsel];
  assign bus.wr_ready  = ~clearing;
  assign bus.swap_busy = (state != IDLE);
  assign bus.swap_done = done_q;
  assign bus.front_sel = front_sel;
endmodule

// File: tb/tb_dbl_framebuf.sv
// Random + directed bench for dbl_framebuf: DUT 0 uses defaults, DUT 1 clears
// to 0x0F0F0F after each swap. Both see identical stimulus.
module tb_dbl_framebuf;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  disp_row = '0;
  logic [5:0]  disp_col = '0;
  logic        frame_end = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  dbl_framebuf_if ia ();
  dbl_framebuf_if ib ();

  assign ia.disp_row = disp_row;   assign ib.disp_row = disp_row;
  assign ia.disp_col = disp_col;   assign ib.disp_col = disp_col;
  assign ia.disp_frame_end = frame_end; assign ib.disp_frame_end = frame_end;
  assign ia.wr_addr = wr_addr;     assign ib.wr_addr = wr_addr;
  assign ia.wr_en = wr_en;         assign ib.wr_en = wr_en;
  assign ia.wr_data = wr_data;     assign ib.wr_data = wr_data;
  assign ia.swap_req = swap_req;   assign ib.swap_req = swap_req;

  dbl_framebuf dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  dbl_framebuf #(.CLEAR_ON_SWAP(1), .CLEAR_VAL(24'h0F0F0F)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bank contents plus swap bookkeeping as plain counters.
  logic [23:0] mm [2][2][DEPTH];
  bit          kn [2][2][DEPTH];
  bit          m_front [2];
  bit          m_pend [2];
  int          m_clr [2];
  logic [23:0] e_pix [2], e_rdq [2];
  bit          e_pk [2], e_rk [2], e_done [2];

  task automatic model_step(input int d);
    logic [2:0] r;
    logic [8:0] da;
    int idx;
    if (!rst_n) begin
      m_front[d] = 0; m_pend[d] = 0; m_clr[d] = 0;
      e_pix[d] = '0; e_pk[d] = 1; e_rdq[d] = '0; e_rk[d] = 1; e_done[d] = 0;
      return;
    end
    r  = disp_row + 3'd1;
    da = {r, disp_col ^ 6'h20};
    e_pix[d] = mm[d][m_front[d]][da];   e_pk[d] = kn[d][m_front[d]][da];
    e_rdq[d] = mm[d][!m_front[d]][wr_addr]; e_rk[d] = kn[d][!m_front[d]][wr_addr];
    e_done[d] = 0;
    if (m_clr[d] > 0) begin
      idx = DEPTH - m_clr[d];
      mm[d][!m_front[d]][idx] = 24'h0F0F0F;
      kn[d][!m_front[d]][idx] = 1;
      m_clr[d]--;
      if (m_clr[d] == 0) e_done[d] = 1;
    end else begin
      if (wr_en) begin
        mm[d][!m_front[d]][wr_addr] = wr_data;
        kn[d][!m_front[d]][wr_addr] = 1;
      end
      if (m_pend[d] && frame_end) begin
        m_front[d] = !m_front[d];
        m_pend[d]  = 0;
        if (d == 1) m_clr[d] = DEPTH;
        else        e_done[d] = 1;
      end else if (!m_pend[d] && swap_req) begin
        m_pend[d] = 1;
      end
    end
  endtask

  task automatic cmp(input int d, input logic [23:0] pix, input logic [23:0] rdq,
                     input logic busy, input logic rdy, input logic done, input logic fs);
    chk($sformatf("m%0d.busy", d), 32'(busy), 32'(m_pend[d] || m_clr[d] > 0));
    chk($sformatf("m%0d.ready", d), 32'(rdy), 32'(m_clr[d] == 0));
    chk($sformatf("m%0d.done", d), 32'(done), 32'(e_done[d]));
    chk($sformatf("m%0d.front", d), 32'(fs), 32'(m_front[d]));
    if (e_pk[d]) chk($sformatf("m%0d.pix", d), 32'(pix), 32'(e_pix[d]));
    if (e_rk[d]) chk($sformatf("m%0d.rd_q", d), 32'(rdq), 32'(e_rdq[d]));
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    cmp(0, {ia.blue, ia.green, ia.red}, ia.rd_q, ia.swap_busy, ia.wr_ready, ia.swap_done, ia.front_sel);
    cmp(1, {ib.blue, ib.green, ib.red}, ib.rd_q, ib.swap_busy, ib.wr_ready, ib.swap_done, ib.front_sel);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_swap_and_frame();
    swap_req = 1; cyc(1); swap_req = 0;
    frame_end = 1; cyc(1); frame_end = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt, donek, seen;
    cyc(3);
    chk("rst.rgb_a", {ia.blue, ia.green, ia.red}, 0);
    chk("rst.rdq_b", ib.rd_q, 0);
    chk("rst.flags_a", {ia.swap_busy, ia.swap_done, ia.wr_ready, ia.front_sel}, 4'b0010);
    chk("rst.flags_b", {ib.swap_busy, ib.swap_done, ib.wr_ready, ib.front_sel}, 4'b0010);
    rst_n = 1; cyc(2);

    // Request without frame end: stays pending.
    swap_req = 1; cyc(1); swap_req = 0; cyc(40);
    chk("stuck.busy", ia.swap_busy, 1);
    chk("stuck.front", ia.front_sel, 0);
    frame_end = 1; cyc(1); frame_end = 0;
    chk("swap.front_a", ia.front_sel, 1);
    chk("swap.done_a", ia.swap_done, 1);
    chk("clr.ready_b", ib.wr_ready, 0);

    // Clear: count ready-low cycles, writes during clear must vanish.
    lowcnt = 0; donek = 0;
    for (int k = 1; k <= 600; k++) begin
      if (!ib.wr_ready) lowcnt++;
      if (ib.swap_done && donek == 0) donek = k;
      if (donek != 0) wr_en = 0;
      else begin wr_en = 1; wr_addr = 9'(k); wr_data = $urandom; end
      cyc(1);
    end
    wr_en = 0;
    chk("clr.lowcnt", lowcnt, 512);
    chk("clr.done_cycle", donek, 513);
    for (int a = 0; a < DEPTH; a++) begin
      wr_addr = 9'(a); cyc(1);
      chk("clr.word", ib.rd_q, 32'h0F0F0F);
    end

    // Swap with a known pixel at address 0.
    wr_en = 1; wr_addr = 9'h000; wr_data = 24'h112233; cyc(1); wr_en = 0;
    pulse_swap_and_frame();
    disp_row = 3'd7; disp_col = 6'd32; cyc(1);
    chk("pix.red", ia.red, 8'h33);
    chk("pix.green", ia.green, 8'h22);
    chk("pix.blue", ia.blue, 8'h11);

    // Read-back and read-first.
    wr_en = 1; wr_addr = 9'h1FF; wr_data = 24'hABCDEF; cyc(1); wr_en = 0; cyc(1);
    chk("rb.q", ia.rd_q, 32'hABCDEF);
    wr_en = 1; wr_data = 24'h000001; cyc(1); wr_en = 0;
    chk("rf.old", ia.rd_q, 32'hABCDEF);
    cyc(1);
    chk("rf.new", ia.rd_q, 32'h000001);
    cyc(520);

    // Request coincident with frame end waits for the next frame end.
    swap_req = 1; frame_end = 1; cyc(1); swap_req = 0; frame_end = 0; cyc(3);
    chk("coinc.front", ia.front_sel, 0);
    chk("coinc.busy", ia.swap_busy, 1);
    frame_end = 1; cyc(1); frame_end = 0;
    chk("coinc.front2", ia.front_sel, 1);
    cyc(520);

    // Repeated requests while pending: exactly one toggle.
    swap_req = 1; cyc(3); swap_req = 0;
    frame_end = 1; cyc(1); frame_end = 0; cyc(2);
    frame_end = 1; cyc(1); frame_end = 0; cyc(2);
    chk("dbl.front", ia.front_sel, 0);
    chk("dbl.busy", ia.swap_busy, 0);
    cyc(520);

    // Reset in the middle of a clear.
    pulse_swap_and_frame();
    chk("abort.pre_ready", ib.wr_ready, 0);
    cyc(100);
    rst_n = 0; #1;
    chk("abort.ready", ib.wr_ready, 1);
    chk("abort.front", ib.front_sel, 0);
    chk("abort.busy", ib.swap_busy, 0);
    cyc(2); rst_n = 1;
    seen = 0;
    for (int k = 0; k < 600; k++) begin
      if (ib.swap_done) seen++;
      cyc(1);
    end
    chk("abort.no_done", seen, 0);

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      disp_row  = 3'($urandom);
      disp_col  = 6'($urandom);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom);
      wr_data   = 24'($urandom);
      swap_req  = ($urandom_range(0, 19) == 0);
      frame_end = ($urandom_range(0, 29) == 0);
      cyc(1);
    end
    swap_req = 0; frame_end = 0; wr_en = 0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
